// File: rtl/streamchk_ctrl_if.sv
// Wishbone pipelined bus between the stream-checker control initiator and the
// checker's control port. The master drives the request, the slave answers.
interface streamchk_ctrl_if;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic        o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        i_wb_stall;
   logic        i_wb_ack;
   logic        i_wb_err;
   logic [31:0] i_wb_data;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
   );
endinterface

// File: rtl/streamchk_ctrl.sv
// Stream checker control initiator: on a start command it writes SEED, then
// LN/DIR/DEV, polls LN until the transfer drains, reads SEED back and compares
// it with seed + words. Reports done/fail/timeout to the bench sequencer.
module streamchk_ctrl #(
   parameter int SW       = 32,
   parameter int POLL_GAP = 16,
   parameter int TIMEOUT  = 1 << 20
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic        i_dir,
   input  logic        i_dev,
   input  logic [29:0] i_len,
   input  logic [31:0] i_seed,
   input  logic        i_chk_err,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_fail,
   output logic        o_timeout,
   output logic [31:0] o_final,
   streamchk_ctrl_if.master wb
);
   localparam int LGW = $clog2(SW / 8);
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int GW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   typedef enum logic [2:0] {IDLE, WSEED, WLEN, GAP, POLL, RFINAL, DONE} state_t;

   state_t      state_q, state_d;
   logic        dir_q, dev_q;
   logic [29:0] len_q;
   logic [31:0] seed_q;
   logic        cyc_q, stb_q, we_q, addr_q;
   logic [31:0] data_q;
   logic [TW-1:0] timer_q;
   logic [GW-1:0] gap_q;
   logic        fail_q, tmo_q;
   logic [31:0] final_q;

   logic        launch, l_we, l_addr;
   logic [31:0] l_data;
   logic        in_op, active, tmo_hit, bus_ack, bus_err, start_ok;
   logic [31:0] ln_word, exp_final;

   assign in_op     = (state_q == WSEED) || (state_q == WLEN) ||
                      (state_q == POLL)  || (state_q == RFINAL);
   assign active    = in_op || (state_q == GAP);
   assign tmo_hit   = active && (timer_q == TMO_MAX);
   assign bus_ack   = cyc_q && wb.i_wb_ack;
   assign bus_err   = cyc_q && wb.i_wb_err;
   assign start_ok  = (state_q == IDLE) && i_start;
   assign ln_word   = {dir_q, dev_q, len_q[29:LGW], {LGW{1'b0}}};
   assign exp_final = seed_q + 32'(len_q >> LGW);

   // Next-state and bus-op launch decode; error or timeout overrides everything.
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      l_we    = 1'b0;
      l_addr  = 1'b0;
      l_data  = '0;
      case (state_q)
         IDLE: if (i_start) begin
            state_d = WSEED;
            launch  = 1'b1;
            l_we    = 1'b1;
            l_addr  = 1'b1;
            l_data  = i_seed;
         end
         WSEED: if (bus_ack) begin
            state_d = WLEN;
            launch  = 1'b1;
            l_we    = 1'b1;
            l_data  = ln_word;
         end
         WLEN: if (bus_ack) state_d = GAP;
         GAP: if (gap_q == GAP_LAST) begin
            state_d = POLL;
            launch  = 1'b1;
         end
         POLL: if (bus_ack) begin
            if (wb.i_wb_data[29:0] == '0) begin
               state_d = RFINAL;
               launch  = 1'b1;
               l_addr  = 1'b1;
            end else begin
               state_d = GAP;
            end
         end
         RFINAL: if (bus_ack) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus_err || tmo_hit) begin
         state_d = DONE;
         launch  = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Command capture; only meaningful while busy, so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (start_ok) begin
         dir_q  <= i_dir;
         dev_q  <= i_dev;
         len_q  <= i_len;
         seed_q <= i_seed;
      end
   end

   // Bus request: stb held until accepted, cyc held until ack/err or abandon.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cyc_q  <= 1'b0;
         stb_q  <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= 1'b0;
         data_q <= '0;
      end else if (launch) begin
         cyc_q  <= 1'b1;
         stb_q  <= 1'b1;
         we_q   <= l_we;
         addr_q <= l_addr;
         data_q <= l_data;
      end else if (bus_ack || bus_err || tmo_hit) begin
         cyc_q <= 1'b0;
         stb_q <= 1'b0;
      end else if (stb_q && !wb.i_wb_stall) begin
         stb_q <= 1'b0;
      end
   end

   // Timer, poll gap counter, sticky status and final readback.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         timer_q <= '0;
         gap_q   <= '0;
         fail_q  <= 1'b0;
         tmo_q   <= 1'b0;
         final_q <= '0;
      end else begin
         gap_q <= (state_q == GAP) ? gap_q + GW'(1) : '0;
         if (start_ok) begin
            timer_q <= TW'(1);
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
         end else begin
            if (active && (timer_q != TMO_MAX)) timer_q <= timer_q + TW'(1);
            if (tmo_hit) begin
               tmo_q  <= 1'b1;
               fail_q <= 1'b1;
            end
            if (bus_err) fail_q <= 1'b1;
            if ((state_q == RFINAL) && bus_ack && !tmo_hit) begin
               final_q <= wb.i_wb_data;
               if ((wb.i_wb_data != exp_final) || i_chk_err) fail_q <= 1'b1;
            end
         end
      end
   end

   // A timed-out op is abandoned in the same cycle the timer saturates.
   assign wb.o_wb_cyc  = cyc_q && !tmo_hit;
   assign wb.o_wb_stb  = stb_q && !tmo_hit;
   assign wb.o_wb_we   = we_q;
   assign wb.o_wb_addr = addr_q;
   assign wb.o_wb_data = data_q;
   assign wb.o_wb_sel  = 4'hf;

   assign o_busy    = active;
   assign o_done    = (state_q == DONE);
   assign o_fail    = fail_q;
   assign o_timeout = tmo_q;
   assign o_final   = final_q;
endmodule

// File: tb/tb_streamchk_ctrl.sv
// Bench for streamchk_ctrl: a Wishbone slave emulating the stream checker
// (SEED/LN registers, stream drain, random stall and ack delay) plus
// scenario tasks checked against a plain-arithmetic reference model.
module tb_streamchk_ctrl;
   localparam int TMO    = 1000;
   localparam int PERIOD = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0, i_dir = 1'b0, i_dev = 1'b0, i_chk_err = 1'b0;
   logic [29:0] i_len = '0;
   logic [31:0] i_seed = '0;
   logic        o_busy, o_done, o_fail, o_timeout;
   logic [31:0] o_final;

   int vectors = 0;
   int miscompares = 0;

   bit stall_en = 0, ack_rand = 0, err_wlen = 0, drain_en = 1, corrupt = 0;
   int polls = 0, seed_wr = 0, ln_wr = 0, proto_viol = 0, sel_viol = 0;
   logic [31:0] last_ln = '0, ln_reg = '0, seed_reg = '0;
   time err_time = 0;

   always #(PERIOD / 2) clk = ~clk;

   streamchk_ctrl_if wb ();

   streamchk_ctrl #(.SW(32), .POLL_GAP(16), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(i_start), .i_dir(i_dir),
      .i_dev(i_dev), .i_len(i_len), .i_seed(i_seed), .i_chk_err(i_chk_err),
      .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_timeout(o_timeout),
      .o_final(o_final), .wb(wb)
   );

   function automatic logic [31:0] model_final(input logic [31:0] seed, input logic [29:0] len);
      int unsigned words;
      words = int'(len) / 4;
      return seed + words;
   endfunction

   function automatic logic [31:0] model_ln(input logic d, input logic dv, input logic [29:0] len);
      logic [29:0] bytes;
      bytes = len - (len % 4);
      return {d, dv, bytes};
   endfunction

   // Checker emulation: register file, drain, stall and response timing.
   initial begin
      bit pv, p_we, p_addr, prev_cyc, prev_stb, prev_stall, prev_we, prev_addr;
      logic [31:0] p_data, prev_data;
      int dly, tick;
      pv = 0; prev_cyc = 0; prev_stb = 0; prev_stall = 0; prev_we = 0; prev_addr = 0;
      p_we = 0; p_addr = 0; p_data = '0; prev_data = '0; dly = 0; tick = 0;
      wb.i_wb_stall = 1'b0; wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_data = '0;
      forever begin
         @(negedge clk);
         wb.i_wb_ack = 1'b0;
         wb.i_wb_err = 1'b0;
         if (wb.o_wb_sel !== 4'hf) sel_viol++;
         if (prev_cyc && prev_stb && prev_stall && wb.o_wb_cyc && !wb.o_wb_stb) proto_viol++;
         if (prev_cyc && prev_stb && !prev_stall) begin
            if (pv) proto_viol++;
            pv = 1; p_we = prev_we; p_addr = prev_addr; p_data = prev_data;
            dly = ack_rand ? int'($urandom_range(0, 3)) : 0;
         end
         if (!wb.o_wb_cyc) pv = 0;
         if (pv) begin
            if (dly == 0) begin
               pv = 0;
               if (err_wlen && p_we && !p_addr) begin
                  wb.i_wb_err = 1'b1;
                  err_time = $time;
               end else begin
                  wb.i_wb_ack = 1'b1;
                  if (p_we && p_addr) begin
                     seed_reg = p_data; seed_wr++;
                  end else if (p_we) begin
                     ln_reg = p_data; last_ln = p_data; ln_wr++; tick = 0;
                  end else begin
                     wb.i_wb_data = p_addr ? seed_reg : ln_reg;
                     if (!p_addr) polls++;
                  end
               end
            end else begin
               dly--;
            end
         end
         if (drain_en && (ln_reg[29:0] != 30'd0)) begin
            tick++;
            if (tick >= 2) begin
               tick = 0;
               ln_reg[29:0] = ln_reg[29:0] - 30'd4;
               seed_reg = seed_reg + 32'd1 + (corrupt ? 32'd1 : 32'd0);
            end
         end
         wb.i_wb_stall = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
         prev_cyc = wb.o_wb_cyc; prev_stb = wb.o_wb_stb; prev_stall = wb.i_wb_stall;
         prev_we = wb.o_wb_we; prev_addr = wb.o_wb_addr; prev_data = wb.o_wb_data;
      end
   end

   task automatic clear_counts();
      polls = 0; seed_wr = 0; ln_wr = 0;
   endtask

   task automatic run_cmd(input logic d, input logic dv, input logic [29:0] len,
                          input logic [31:0] seed, input int restart_at,
                          output bit got, output int ncyc, output logic f, output logic t,
                          output logic [31:0] fin, output time tdone, output logic busy1);
      @(negedge clk);
      i_dir = d; i_dev = dv; i_len = len; i_seed = seed; i_start = 1'b1;
      got = 0; ncyc = 0; f = 1'bx; t = 1'bx; fin = 'x; tdone = 0; busy1 = 1'bx;
      while (!got && ncyc < 5000) begin
         @(negedge clk);
         ncyc++;
         i_start = (ncyc == restart_at);
         if (ncyc == restart_at) i_seed = ~seed;
         if (ncyc == 1) busy1 = o_busy;
         if (o_done) begin
            got = 1; f = o_fail; t = o_timeout; fin = o_final; tdone = $time;
         end
      end
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", o_done); end
      vectors++; if ({o_fail, o_timeout} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {o_fail, o_timeout}); end
      vectors++; if (o_final !== 32'h0) begin miscompares++; $display("FAIL reset_final: got %h want 0", o_final); end
      vectors++; if ({wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we} !== 3'b000) begin miscompares++; $display("FAIL reset_bus: got %b want 000", {wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we}); end
      vectors++; if (wb.o_wb_sel !== 4'hf) begin miscompares++; $display("FAIL reset_sel: got %h want f", wb.o_wb_sel); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      run_cmd(1'b1, 1'b0, 30'd64, 32'h100, 0, got, n, f, t, fin, td, b);
      vectors++; if (!got) begin miscompares++; $display("FAIL basic_done: no o_done within %0d cycles", n); end
      vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", b); end
      vectors++; if (fin !== model_final(32'h100, 30'd64)) begin miscompares++; $display("FAIL basic_final: got %h want %h", fin, model_final(32'h100, 30'd64)); end
      vectors++; if ({f, t} !== 2'b00) begin miscompares++; $display("FAIL basic_flags: got %b want 00", {f, t}); end
      vectors++; if (last_ln !== model_ln(1'b1, 1'b0, 30'd64)) begin miscompares++; $display("FAIL basic_ln: got %h want %h", last_ln, model_ln(1'b1, 1'b0, 30'd64)); end
      vectors++; if (seed_wr !== 1) begin miscompares++; $display("FAIL basic_seedwr: got %0d want 1", seed_wr); end
      @(negedge clk);
      vectors++; if ({o_done, o_busy} !== 2'b00) begin miscompares++; $display("FAIL basic_pulse: got %b want 00", {o_done, o_busy}); end
   endtask

   task automatic test_len_zero();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      run_cmd(1'b0, 1'b0, 30'd0, 32'hFFFF_FFFF, 0, got, n, f, t, fin, td, b);
      vectors++; if (!got) begin miscompares++; $display("FAIL len0_done: no o_done within %0d cycles", n); end
      vectors++; if (fin !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL len0_final: got %h want ffffffff", fin); end
      vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL len0_fail: got %b want 0", f); end
      vectors++; if (polls !== 1) begin miscompares++; $display("FAIL len0_polls: got %0d want 1", polls); end
      vectors++; if (last_ln !== 32'h0) begin miscompares++; $display("FAIL len0_ln: got %h want 0", last_ln); end
   endtask

   task automatic test_wrap();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      run_cmd(1'b0, 1'b1, 30'd16, 32'hFFFF_FFFE, 0, got, n, f, t, fin, td, b);
      vectors++; if (fin !== 32'h0000_0002) begin miscompares++; $display("FAIL wrap_final: got %h want 00000002", fin); end
      vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL wrap_fail: got %b want 0", f); end
      vectors++; if (last_ln !== 32'h4000_0010) begin miscompares++; $display("FAIL wrap_ln: got %h want 40000010", last_ln); end
   endtask

   task automatic test_stall();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      stall_en = 1; ack_rand = 1; proto_viol = 0; sel_viol = 0;
      for (int i = 0; i < 3; i++) begin
         clear_counts();
         run_cmd(1'b1, 1'b0, 30'd64, 32'h100, 0, got, n, f, t, fin, td, b);
         vectors++; if (fin !== 32'h110 || f !== 1'b0) begin miscompares++; $display("FAIL stall_result[%0d]: got final %h fail %b want 110/0", i, fin, f); end
      end
      stall_en = 0; ack_rand = 0;
      vectors++; if (proto_viol !== 0) begin miscompares++; $display("FAIL stall_protocol: got %0d violations want 0", proto_viol); end
      vectors++; if (sel_viol !== 0) begin miscompares++; $display("FAIL stall_sel: got %0d bad sel cycles want 0", sel_viol); end
   endtask

   task automatic test_timeout();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      drain_en = 0;
      run_cmd(1'b1, 1'b0, 30'd64, 32'h100, 0, got, n, f, t, fin, td, b);
      vectors++; if (!got) begin miscompares++; $display("FAIL tmo_done: no o_done within %0d cycles", n); end
      vectors++; if ({t, f} !== 2'b11) begin miscompares++; $display("FAIL tmo_flags: got %b want 11", {t, f}); end
      vectors++; if (n < TMO - 5 || n > TMO + 2) begin miscompares++; $display("FAIL tmo_latency: got %0d cycles want %0d..%0d", n, TMO - 5, TMO + 2); end
      vectors++; if (wb.o_wb_cyc !== 1'b0) begin miscompares++; $display("FAIL tmo_cyc: got %b want 0", wb.o_wb_cyc); end
      drain_en = 1;
      ln_reg = '0;
   endtask

   task automatic test_wb_err();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      err_wlen = 1;
      run_cmd(1'b1, 1'b0, 30'd64, 32'h100, 0, got, n, f, t, fin, td, b);
      err_wlen = 0;
      vectors++; if ({f, t} !== 2'b10) begin miscompares++; $display("FAIL err_flags: got %b want 10", {f, t}); end
      vectors++; if (polls !== 0) begin miscompares++; $display("FAIL err_polls: got %0d want 0", polls); end
      vectors++; if (td - err_time !== time'(PERIOD)) begin miscompares++; $display("FAIL err_latency: got %0t want %0d", td - err_time, PERIOD); end
      clear_counts();
      run_cmd(1'b1, 1'b0, 30'd64, 32'h100, 0, got, n, f, t, fin, td, b);
      vectors++; if ({f, t} !== 2'b00 || fin !== 32'h110) begin miscompares++; $display("FAIL err_recover: got flags %b final %h want 00/110", {f, t}, fin); end
   endtask

   task automatic test_chk_err();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      i_chk_err = 1'b1;
      run_cmd(1'b0, 1'b0, 30'd32, 32'h55, 0, got, n, f, t, fin, td, b);
      i_chk_err = 1'b0;
      vectors++; if (fin !== 32'h5D) begin miscompares++; $display("FAIL chkerr_final: got %h want 5d", fin); end
      vectors++; if ({f, t} !== 2'b10) begin miscompares++; $display("FAIL chkerr_flags: got %b want 10", {f, t}); end
   endtask

   task automatic test_mismatch();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      corrupt = 1;
      run_cmd(1'b1, 1'b1, 30'd32, 32'h1000, 0, got, n, f, t, fin, td, b);
      corrupt = 0;
      vectors++; if (fin !== 32'h1010) begin miscompares++; $display("FAIL mismatch_final: got %h want 1010", fin); end
      vectors++; if (f !== 1'b1) begin miscompares++; $display("FAIL mismatch_fail: got %b want 1", f); end
   endtask

   task automatic test_busy_ignore();
      bit got; int n; logic f, t, b; logic [31:0] fin; time td;
      clear_counts();
      run_cmd(1'b1, 1'b0, 30'd64, 32'h100, 4, got, n, f, t, fin, td, b);
      vectors++; if (fin !== 32'h110 || f !== 1'b0) begin miscompares++; $display("FAIL busyign_result: got final %h fail %b want 110/0", fin, f); end
      vectors++; if (seed_wr !== 1 || ln_wr !== 1) begin miscompares++; $display("FAIL busyign_writes: got seed %0d ln %0d want 1/1", seed_wr, ln_wr); end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      i_dir = 1'b1; i_dev = 1'b0; i_len = 30'd64; i_seed = 32'h100; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      vectors++; if (wb.o_wb_cyc !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: got cyc %b want 1", wb.o_wb_cyc); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if ({wb.o_wb_cyc, wb.o_wb_stb, o_busy} !== 3'b000) begin miscompares++; $display("FAIL midrst_async: got %b want 000", {wb.o_wb_cyc, wb.o_wb_stb, o_busy}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if ({o_busy, o_done} !== 2'b00) begin miscompares++; $display("FAIL midrst_idle: got %b want 00", {o_busy, o_done}); end
   endtask

   task automatic test_random();
      bit got; int n; logic f, t, b, d, dv; logic [31:0] fin, seed; logic [29:0] len; time td;
      for (int i = 0; i < 10; i++) begin
         stall_en = ($urandom_range(0, 1) == 1);
         ack_rand = ($urandom_range(0, 1) == 1);
         d = ($urandom_range(0, 1) == 1);
         dv = ($urandom_range(0, 1) == 1);
         len = 30'($urandom_range(0, 255));
         seed = $urandom();
         clear_counts();
         run_cmd(d, dv, len, seed, 0, got, n, f, t, fin, td, b);
         vectors++; if (fin !== model_final(seed, len) || f !== 1'b0) begin miscompares++; $display("FAIL rand_result[%0d]: got final %h fail %b want %h/0 (seed %h len %0d)", i, fin, f, model_final(seed, len), seed, len); end
         vectors++; if (last_ln !== model_ln(d, dv, len)) begin miscompares++; $display("FAIL rand_ln[%0d]: got %h want %h", i, last_ln, model_ln(d, dv, len)); end
      end
      stall_en = 0; ack_rand = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_wrap();
      test_stall();
      test_timeout();
      test_wb_err();
      test_chk_err();
      test_mismatch();
      test_busy_ignore();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
